bpu_gshare: RTL and testbench

Parametrised gshare branch prediction unit for the RV32I pipelined core. It is the successor to the fixed-size BPU and adds a configurable pattern history table (PHT), a tagged branch target buffer (BTB) and a speculative global history register (GHR) with checkpoint recovery. It also adds in-block misprediction detection with a redirect PC and saturating performance counters. Fetch gets its prediction in the same cycle; resolution arrives from EX.

---
 rtl/bpu_gshare_if.sv | 38 +++
 rtl/bpu_gshare.sv | 100 ++++++++++
 tb/tb_bpu_gshare.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_gshare_if.sv
// Fetch/resolve signal bundle between the pipeline and the gshare branch predictor.
// master = pipeline side (fetch + EX), slave = predictor.
interface bpu_gshare_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned GHR_W = 8,
  parameter int unsigned CNT_W = 32
);
  logic             fetch_valid;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  predicted_pc;
  logic             prediction_taken;
  logic             prediction_valid;
  logic [GHR_W-1:0] ghr_out;
  logic             resolve_valid;
  logic [XLEN-1:0]  resolve_pc;
  logic             resolve_taken;
  logic [XLEN-1:0]  resolve_target;
  logic [GHR_W-1:0] resolve_ghr;
  logic [XLEN-1:0]  resolve_pred_pc;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output fetch_valid, pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
           resolve_ghr, resolve_pred_pc,
    input  predicted_pc, prediction_taken, prediction_valid, ghr_out, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  fetch_valid, pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
           resolve_ghr, resolve_pred_pc,
    output predicted_pc, prediction_taken, prediction_valid, ghr_out, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/bpu_gshare.sv
// Gshare/bimodal branch predictor: 2-bit PHT, tagged BTB, speculative GHR with
// checkpoint recovery, in-block mispredict detection and saturating perf counters.
module bpu_gshare #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned GHR_W      = 8,
  parameter int unsigned PHT_IDX_W  = 8,
  parameter int unsigned BTB_IDX_W  = 4,
  parameter bit          USE_GSHARE = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input logic         clk,
  input logic         rst,
  bpu_gshare_if.slave bus
);
  localparam int unsigned PhtEntries = 2 ** PHT_IDX_W;
  localparam int unsigned BtbEntries = 2 ** BTB_IDX_W;
  localparam int unsigned TagW       = XLEN - BTB_IDX_W - 2;

  logic [1:0]            pht_q        [PhtEntries];
  logic [BtbEntries-1:0] btb_valid_q;
  logic [TagW-1:0]       btb_tag_q    [BtbEntries];
  logic [XLEN-1:0]       btb_target_q [BtbEntries];
  logic [GHR_W-1:0]      ghr_q;
  logic [CNT_W-1:0]      branch_count_q;
  logic [CNT_W-1:0]      mispredict_count_q;

  function automatic logic [PHT_IDX_W-1:0] pidx(input logic [XLEN-1:0]  p,
                                                input logic [GHR_W-1:0] h);
    logic [PHT_IDX_W-1:0] idx;
    idx = p[PHT_IDX_W+1:2];
    if (USE_GSHARE) idx = idx ^ PHT_IDX_W'(h);
    return idx;
  endfunction

  logic [BTB_IDX_W-1:0] f_bidx;
  logic [BTB_IDX_W-1:0] r_bidx;
  logic [PHT_IDX_W-1:0] f_pidx;
  logic [PHT_IDX_W-1:0] r_pidx;
  logic                 hit;
  logic                 taken_pred;
  logic                 res_live;
  logic                 mispredict;
  logic [XLEN-1:0]      pc_plus4;
  logic [XLEN-1:0]      actual_pc;

  // Lookup reads only registered state, so a same-cycle resolve is invisible here.
  always_comb begin
    f_bidx     = bus.pc[BTB_IDX_W+1:2];
    r_bidx     = bus.resolve_pc[BTB_IDX_W+1:2];
    f_pidx     = pidx(bus.pc, ghr_q);
    r_pidx     = pidx(bus.resolve_pc, bus.resolve_ghr);
    hit        = bus.fetch_valid & ~rst & btb_valid_q[f_bidx] &
                 (btb_tag_q[f_bidx] == bus.pc[XLEN-1:BTB_IDX_W+2]);
    taken_pred = hit & pht_q[f_pidx][1];
    pc_plus4   = bus.pc + XLEN'(4);
    actual_pc  = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + XLEN'(4);
    res_live   = bus.resolve_valid & ~rst;
    mispredict = res_live & (actual_pc != bus.resolve_pred_pc);
  end

  assign bus.prediction_valid = hit;
  assign bus.prediction_taken = taken_pred;
  assign bus.predicted_pc     = taken_pred ? btb_target_q[f_bidx] : pc_plus4;
  assign bus.ghr_out          = rst ? '0 : ghr_q;
  assign bus.mispredict       = mispredict;
  assign bus.redirect_pc      = res_live ? actual_pc : '0;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PhtEntries); i++) pht_q[i] <= 2'b01;
      btb_valid_q        <= '0;
      ghr_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (bus.resolve_valid) begin
        if (bus.resolve_taken) begin
          if (pht_q[r_pidx] != 2'b11) pht_q[r_pidx] <= pht_q[r_pidx] + 2'b01;
          btb_valid_q[r_bidx]  <= 1'b1;
          btb_tag_q[r_bidx]    <= bus.resolve_pc[XLEN-1:BTB_IDX_W+2];
          btb_target_q[r_bidx] <= bus.resolve_target;
        end else if (pht_q[r_pidx] != 2'b00) begin
          pht_q[r_pidx] <= pht_q[r_pidx] - 2'b01;
        end
        if (branch_count_q != '1) branch_count_q <= branch_count_q + 1'b1;
        if (mispredict && (mispredict_count_q != '1)) begin
          mispredict_count_q <= mispredict_count_q + 1'b1;
        end
      end
      // Recovery from the resolved checkpoint beats the speculative shift.
      if (mispredict) begin
        ghr_q <= {bus.resolve_ghr[GHR_W-2:0], bus.resolve_taken};
      end else if (hit) begin
        ghr_q <= {ghr_q[GHR_W-2:0], taken_pred};
      end
    end
  end
endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: gshare (narrow counters) and bimodal instances driven in lockstep,
// each compared every cycle against an arithmetic reference model.
module tb_bpu_gshare;
  logic        clk;
  logic        rst;
  logic        fv;
  logic [31:0] pc;
  logic        rv;
  logic [31:0] rpc;
  logic        rt;
  logic [31:0] rtgt;
  logic [7:0]  rghr;
  logic [31:0] rpred;

  int checks;
  int failures;

  bpu_gshare_if #(.XLEN(32), .GHR_W(8), .CNT_W(5))  if_g ();
  bpu_gshare_if #(.XLEN(32), .GHR_W(8), .CNT_W(32)) if_b ();

  assign if_g.fetch_valid     = fv;
  assign if_g.pc              = pc;
  assign if_g.resolve_valid   = rv;
  assign if_g.resolve_pc      = rpc;
  assign if_g.resolve_taken   = rt;
  assign if_g.resolve_target  = rtgt;
  assign if_g.resolve_ghr     = rghr;
  assign if_g.resolve_pred_pc = rpred;
  assign if_b.fetch_valid     = fv;
  assign if_b.pc              = pc;
  assign if_b.resolve_valid   = rv;
  assign if_b.resolve_pc      = rpc;
  assign if_b.resolve_taken   = rt;
  assign if_b.resolve_target  = rtgt;
  assign if_b.resolve_ghr     = rghr;
  assign if_b.resolve_pred_pc = rpred;

  bpu_gshare #(.USE_GSHARE(1'b1), .CNT_W(5)) dut_g (.clk(clk), .rst(rst), .bus(if_g));
  bpu_gshare #(.USE_GSHARE(1'b0), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state; index 0 = gshare instance, 1 = bimodal instance.
  int          pht   [2][256];
  bit          bv    [2][16];
  logic [31:0] btag  [2][16];
  logic [31:0] btgt  [2][16];
  int          ghr_m [2];
  longint      bc    [2];
  longint      mc    [2];
  longint      cmax  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_comb(input int m, output logic pv, output logic pt,
                                     output logic [31:0] ppc, output logic [7:0] gout,
                                     output logic mis, output logic [31:0] redir);
    int          bi;
    int          pi;
    logic [31:0] actual;
    bi     = int'((pc >> 2) % 16);
    pi     = int'((pc >> 2) % 256);
    if (m == 0) pi = pi ^ ghr_m[m];
    pv     = !rst && fv && bv[m][bi] && (btag[m][bi] == (pc >> 6));
    pt     = pv && (pht[m][pi] >= 2);
    ppc    = pt ? btgt[m][bi] : pc + 32'd4;
    gout   = rst ? 8'd0 : 8'(ghr_m[m]);
    actual = rt ? rtgt : rpc + 32'd4;
    mis    = !rst && rv && (actual != rpred);
    redir  = (!rst && rv) ? actual : 32'd0;
  endfunction

  task automatic model_commit();
    logic        pv, pt, mis;
    logic [31:0] ppc, redir;
    logic [7:0]  gout;
    int          ri;
    int          bi;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) pht[m][i] = 1;
        for (int i = 0; i < 16; i++) bv[m][i] = 1'b0;
        ghr_m[m] = 0;
        bc[m]    = 0;
        mc[m]    = 0;
      end else begin
        model_comb(m, pv, pt, ppc, gout, mis, redir);
        if (rv) begin
          ri = int'((rpc >> 2) % 256);
          if (m == 0) ri = ri ^ int'(rghr);
          if (rt) begin
            if (pht[m][ri] < 3) pht[m][ri]++;
            bi = int'((rpc >> 2) % 16);
            bv[m][bi]   = 1'b1;
            btag[m][bi] = rpc >> 6;
            btgt[m][bi] = rtgt;
          end else if (pht[m][ri] > 0) begin
            pht[m][ri]--;
          end
          if (bc[m] < cmax[m]) bc[m]++;
          if (mis && (mc[m] < cmax[m])) mc[m]++;
        end
        if (mis) ghr_m[m] = ((int'(rghr) << 1) | int'(rt)) & 255;
        else if (pv) ghr_m[m] = ((ghr_m[m] << 1) | int'(pt)) & 255;
      end
    end
  endtask

  task automatic check_all();
    logic        pv, pt, mis;
    logic [31:0] ppc, redir;
    logic [7:0]  gout;
    for (int m = 0; m < 2; m++) begin
      model_comb(m, pv, pt, ppc, gout, mis, redir);
      chk($sformatf("prediction_valid[%0d]", m),
          (m == 0) ? if_g.prediction_valid : if_b.prediction_valid, pv);
      chk($sformatf("prediction_taken[%0d]", m),
          (m == 0) ? if_g.prediction_taken : if_b.prediction_taken, pt);
      chk($sformatf("predicted_pc[%0d]", m),
          (m == 0) ? if_g.predicted_pc : if_b.predicted_pc, ppc);
      chk($sformatf("ghr_out[%0d]", m), (m == 0) ? if_g.ghr_out : if_b.ghr_out, gout);
      chk($sformatf("mispredict[%0d]", m), (m == 0) ? if_g.mispredict : if_b.mispredict, mis);
      chk($sformatf("redirect_pc[%0d]", m),
          (m == 0) ? if_g.redirect_pc : if_b.redirect_pc, redir);
      chk($sformatf("branch_count[%0d]", m),
          (m == 0) ? 64'(if_g.branch_count) : 64'(if_b.branch_count), bc[m]);
      chk($sformatf("mispredict_count[%0d]", m),
          (m == 0) ? 64'(if_g.mispredict_count) : 64'(if_b.mispredict_count), mc[m]);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic commit();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic resolve(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                         input logic [7:0] h, input logic [31:0] pred);
    fv = 1'b0; rv = 1'b1; rpc = p; rt = t; rtgt = tgt; rghr = h; rpred = pred;
  endtask

  task automatic fetch(input logic [31:0] p);
    fv = 1'b1; pc = p; rv = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'($urandom_range(0, 31)) << 2;
    if ($urandom_range(0, 3) == 0) p = p | 32'hFFFF_FF80;
    return p;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    cmax[0] = 64'd31;
    cmax[1] = 64'hFFFF_FFFF;
    // Reset cycle with a live resolve: outputs forced, resolve discarded.
    rst = 1'b1; fv = 1'b1; pc = 32'h08;
    rv = 1'b1; rpc = 32'h08; rt = 1'b1; rtgt = 32'h20; rghr = 8'h00; rpred = 32'h0C;
    @(negedge clk);
    chk("rst_pv", if_g.prediction_valid, 1'b0);
    chk("rst_pt", if_g.prediction_taken, 1'b0);
    chk("rst_ppc", if_g.predicted_pc, 32'h0C);
    chk("rst_ghr", if_g.ghr_out, 8'h00);
    chk("rst_mis", if_g.mispredict, 1'b0);
    chk("rst_redir", if_g.redirect_pc, 32'h0);
    commit();
    rst = 1'b0;

    fetch(32'h08);
    settle();
    chk("cold_pv", if_g.prediction_valid, 1'b0);
    chk("cold_ppc", if_g.predicted_pc, 32'h0C);
    chk("cold_bc", 64'(if_g.branch_count), 64'd0);
    chk("cold_mc", 64'(if_g.mispredict_count), 64'd0);
    commit();

    resolve(32'h08, 1'b1, 32'h20, 8'h00, 32'h0C);
    settle();
    chk("train_mis", if_g.mispredict, 1'b1);
    chk("train_redir", if_g.redirect_pc, 32'h20);
    commit();

    resolve(32'h08, 1'b1, 32'h20, 8'h01, 32'h20);
    settle();
    chk("train_ghr", if_g.ghr_out, 8'h01);
    chk("train_bc", 64'(if_g.branch_count), 64'd1);
    chk("train_mc", 64'(if_g.mispredict_count), 64'd1);
    chk("train2_mis", if_g.mispredict, 1'b0);
    commit();

    fetch(32'h08);
    settle();
    chk("hit_pv", if_g.prediction_valid, 1'b1);
    chk("hit_pt", if_g.prediction_taken, 1'b1);
    chk("hit_ppc", if_g.predicted_pc, 32'h20);
    chk("hit_ghr", if_g.ghr_out, 8'h01);
    commit();
    fv = 1'b0;
    settle();
    chk("spec_ghr", if_g.ghr_out, 8'h03);
    commit();

    // Wrap: BTB hit at the top of the address space with a weak-not-taken counter.
    resolve(32'hFFFF_FFFC, 1'b1, 32'h40, 8'h00, 32'h0);
    settle();
    chk("wrap_train_mis", if_g.mispredict, 1'b1);
    commit();
    fetch(32'hFFFF_FFFC);
    settle();
    chk("wrap_pv", if_g.prediction_valid, 1'b1);
    chk("wrap_pt", if_g.prediction_taken, 1'b0);
    chk("wrap_ppc", if_g.predicted_pc, 32'h0);
    commit();

    // Same-cycle taken fetch hit and mispredicting resolve.
    resolve(32'h08, 1'b1, 32'h20, 8'h00, 32'h0C);
    settle();
    commit();
    resolve(32'h100, 1'b0, 32'h0, 8'h05, 32'h200);
    fv = 1'b1; pc = 32'h08;
    settle();
    chk("simul_pt", if_g.prediction_taken, 1'b1);
    chk("simul_mis", if_g.mispredict, 1'b1);
    commit();
    fv = 1'b0; rv = 1'b0;
    settle();
    chk("simul_ghr", if_g.ghr_out, 8'h0A);
    commit();

    // Saturation: 3 taken then not-taken steps on one entry, GHR pinned at 0.
    resolve(32'h200, 1'b0, 32'h0, 8'h00, 32'h0);
    settle();
    commit();
    for (int k = 0; k < 3; k++) begin
      resolve(32'h30, 1'b1, 32'h80, 8'h00, 32'h80);
      settle();
      chk("sat_up_mis", if_g.mispredict, 1'b0);
      commit();
    end
    resolve(32'h30, 1'b0, 32'h80, 8'h00, 32'h34);
    settle();
    commit();
    fetch(32'h30);
    settle();
    chk("sat10_pt", if_g.prediction_taken, 1'b1);
    chk("sat10_ppc", if_g.predicted_pc, 32'h80);
    commit();
    resolve(32'h30, 1'b0, 32'h80, 8'h00, 32'h80);
    settle();
    chk("sat_dn_mis", if_g.mispredict, 1'b1);
    commit();
    fetch(32'h30);
    settle();
    chk("sat01_pv", if_g.prediction_valid, 1'b1);
    chk("sat01_pt", if_g.prediction_taken, 1'b0);
    chk("sat01_ppc", if_g.predicted_pc, 32'h34);
    commit();

    // Bimodal: resolves with different histories land on one counter.
    resolve(32'h10, 1'b1, 32'h60, 8'h12, 32'h60);
    settle();
    commit();
    resolve(32'h10, 1'b1, 32'h60, 8'h34, 32'h60);
    settle();
    commit();
    resolve(32'h10, 1'b0, 32'h60, 8'h56, 32'h14);
    settle();
    commit();
    for (int k = 0; k < 2; k++) begin
      fetch(32'h10);
      settle();
      chk("bimodal_pv", if_b.prediction_valid, 1'b1);
      chk("bimodal_pt", if_b.prediction_taken, 1'b1);
      chk("bimodal_ppc", if_b.predicted_pc, 32'h60);
      commit();
    end

    // Randomized traffic, including occasional reset with a live resolve.
    for (int n = 0; n < 500; n++) begin
      rst  = ($urandom_range(0, 63) == 0);
      fv   = 1'($urandom_range(0, 1));
      pc   = rand_pc();
      rv   = 1'($urandom_range(0, 1));
      rpc  = rand_pc();
      rt   = 1'($urandom_range(0, 1));
      rtgt = rand_pc();
      rghr = 8'($urandom);
      rpred = ($urandom_range(0, 1) == 1) ? (rt ? rtgt : rpc + 32'd4) : rand_pc();
      settle();
      commit();
    end
    rst = 1'b0;

    // Drive the narrow mispredict counter past all-ones.
    for (int n = 0; n < 40; n++) begin
      resolve(32'h300, 1'b0, 32'h0, 8'($urandom), 32'h0);
      settle();
      commit();
    end
    rv = 1'b0;
    settle();
    chk("mc_saturated", 64'(if_g.mispredict_count), 64'd31);
    chk("bc_saturated", 64'(if_g.branch_count), 64'd31);
    commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
